// File: rtl/systolic_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_sched
// Brief    : Tile sequencer for a weight-stationary systolic MAC array.
//            Runs weight preload, skewed activation stream, flush and drain.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_sched #(
    parameter int ARRAY_N = 4,
    parameter int ADDR_W  = 8,
    parameter int K_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    output logic               busy,
    output logic               done,
    output logic               w_load_en,
    output logic [ADDR_W-1:0]  w_rd_addr,
    output logic               a_rd_en,
    output logic [ADDR_W-1:0]  a_rd_addr,
    output logic [ARRAY_N-1:0] row_valid,
    output logic               acc_clear,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_row
);

    localparam int CNT_W = (ADDR_W > K_W) ? ADDR_W : K_W;
    localparam logic [CNT_W-1:0] c_n_last     = CNT_W'(ARRAY_N - 1);
    localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(2 * ARRAY_N - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_k_last;
    logic [K_W-1:0]     r_k_len;
    logic               w_rd_strobe;
    logic               r_w_load_en;
    logic [ARRAY_N-1:0] r_skew;

    assign w_k_last  = CNT_W'(r_k_len) - CNT_W'(1);
    assign w_load_en = r_w_load_en;
    assign row_valid = r_skew;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_k_len     <= '0;
            r_w_load_en <= 1'b0;
            r_skew      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_w_load_en <= w_rd_strobe;
            if (r_state == S_IDLE && start && k_len != '0)
                r_k_len <= k_len;
            // Stage i carries a_rd_en delayed by i+1: SRAM latency plus diagonal skew
            r_skew[0] <= a_rd_en;
            for (int i = 1; i < ARRAY_N; i++)
                r_skew[i] <= r_skew[i-1];
        end
    end

    // Every phase reloads the counter to 0 on entry and exits on count == len-1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        w_rd_strobe = 1'b0;
        w_rd_addr   = '0;
        a_rd_en     = 1'b0;
        a_rd_addr   = '0;
        acc_clear   = 1'b0;
        out_valid   = 1'b0;
        out_row     = '0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start && k_len != '0)
                    w_state_nxt = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_rd_strobe = 1'b1;
                w_rd_addr   = ADDR_W'(r_cnt);
                if (r_cnt == c_n_last) begin
                    w_state_nxt = S_STREAM;
                    w_cnt_nxt   = '0;
                end
            end
            S_STREAM: begin
                a_rd_en   = 1'b1;
                a_rd_addr = ADDR_W'(r_cnt);
                acc_clear = (r_cnt == '0);
                if (r_cnt == w_k_last) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FLUSH: begin
                if (r_cnt == c_flush_last) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_row   = ADDR_W'(r_cnt);
                if (r_cnt == c_n_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_sched
// Brief    : Self-checking bench; per-cycle expected outputs queued at launch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_sched;

    localparam int ARRAY_N = 4;
    localparam int ADDR_W  = 8;
    localparam int K_W     = 8;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               w_load_en;
        logic [ADDR_W-1:0]  w_rd_addr;
        logic               a_rd_en;
        logic [ADDR_W-1:0]  a_rd_addr;
        logic [ARRAY_N-1:0] row_valid;
        logic               acc_clear;
        logic               out_valid;
        logic [ADDR_W-1:0]  out_row;
    } outs_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [K_W-1:0]     k_len = '0;
    logic               busy, done, w_load_en, a_rd_en, acc_clear, out_valid;
    logic [ADDR_W-1:0]  w_rd_addr, a_rd_addr, out_row;
    logic [ARRAY_N-1:0] row_valid;

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_done = 0;
    bit    chk_en = 1'b0;
    bit    skew_en = 1'b0;
    outs_t exp_q[$];
    outs_t mon_e, mon_o;
    logic [15:0] a_hist = '0;

    systolic_tile_sched #(.ARRAY_N(ARRAY_N), .ADDR_W(ADDR_W), .K_W(K_W)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .w_load_en(w_load_en), .w_rd_addr(w_rd_addr),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .row_valid(row_valid),
        .acc_clear(acc_clear), .out_valid(out_valid), .out_row(out_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs c cycles after the accepting edge, from the tile timeline
    function automatic outs_t tile_exp(input int c, input int k);
        outs_t e;
        int n = ARRAY_N;
        e = '0;
        e.busy      = (c >= 1 && c <= 4*n + k);
        e.done      = (c == 4*n + k);
        e.w_rd_addr = (c >= 1 && c <= n) ? ADDR_W'(c - 1) : '0;
        e.w_load_en = (c >= 2 && c <= n + 1);
        e.a_rd_en   = (c >= n + 1 && c <= n + k);
        e.a_rd_addr = e.a_rd_en ? ADDR_W'(c - n - 1) : '0;
        e.acc_clear = (c == n + 1);
        for (int i = 0; i < n; i++)
            e.row_valid[i] = (c - i - 1 >= n + 1) && (c - i - 1 <= n + k);
        e.out_valid = (c >= 3*n + k && c <= 4*n + k - 1);
        e.out_row   = e.out_valid ? ADDR_W'(c - 3*n - k) : '0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            mon_o = '{busy, done, w_load_en, w_rd_addr, a_rd_en, a_rd_addr,
                      row_valid, acc_clear, out_valid, out_row};
            mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : outs_t'('0);
            check("outs", 64'(mon_o), 64'(mon_e));
            if (done) n_done++;
            a_hist = {a_hist[14:0], a_rd_en};
            if (skew_en) begin
                for (int i = 0; i < ARRAY_N; i++)
                    check($sformatf("skew_row%0d", i), 64'(row_valid[i]), 64'(a_hist[i+1]));
                check("out_row_max", 64'(out_row <= ADDR_W'(ARRAY_N - 1)), 64'(1));
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    // Waits for the previous tile plus one idle cycle, then issues a tile
    task automatic launch(input int k);
        wait_idle();
        @(negedge clk); #1;
        start = 1'b1;
        k_len = K_W'(k);
        for (int c = 1; c <= 4*ARRAY_N + k; c++)
            exp_q.push_back(tile_exp(c, k));
        @(negedge clk); #1;
        start = 1'b0;
        k_len = '0;
    endtask

    task automatic poke_start(input int k);
        start = 1'b1;
        k_len = K_W'(k);
        @(negedge clk); #1;
        start = 1'b0;
        k_len = '0;
    endtask

    initial begin
        int d0;
        // Reset held with start asserted
        start = 1'b1;
        k_len = 8'd8;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        k_len = '0;
        check("done_in_reset", 64'(n_done), 64'(0));

        // Nominal tile
        launch(8);
        wait_idle();

        // Single-vector tile, then zero-length request ignored
        launch(1);
        wait_idle();
        @(negedge clk); #1;
        poke_start(0);
        repeat (6) @(negedge clk);
        #1;
        check("k0_busy", 64'(busy), 64'(0));

        // Starts during STREAM and DRAIN ignored; back-to-back tile
        d0 = n_done;
        launch(8);
        repeat (6) @(negedge clk);
        #1;
        poke_start(3);
        repeat (15) @(negedge clk);
        #1;
        poke_start(5);
        launch(8);
        wait_idle();
        @(negedge clk); #1;
        check("done_count", 64'(n_done - d0), 64'(2));

        // Reset mid-STREAM
        d0 = n_done;
        launch(8);
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        check("abort_no_done", 64'(n_done - d0), 64'(0));
        launch(6);
        wait_idle();

        // Maximum stream length with skew relation checked every cycle
        repeat (ARRAY_N + 2) @(negedge clk);
        #1;
        skew_en = 1'b1;
        launch(255);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        skew_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
